// File: rtl/mxm_pkg.sv
// Shared sizing helpers and the rounding/saturation arithmetic for the MxM MAC array.
// Everything here is pure combinational math used by the lane and top modules.
package mxm_pkg;

  localparam int RS_W = 64;
  localparam logic signed [RS_W-1:0] RS_ONE = 1;

  typedef struct packed {
    logic                   sat;
    logic signed [RS_W-1:0] y;
  } rs_t;

  function automatic int nw_of(input int nmax);
    return $clog2(nmax + 1);
  endfunction

  function automatic int acc_w_of(input int w, input int nmax);
    return 2 * w + $clog2(nmax);
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Round half up by f bits, then clamp to a signed w-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] s, input int w, input int f);
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    if (f == 0) r = s;
    else        r = (s + (RS_ONE <<< (f - 1))) >>> f;
    hi = (RS_ONE <<< (w - 1)) - RS_ONE;
    lo = -(RS_ONE <<< (w - 1));
    res.sat = (r > hi) || (r < lo);
    if (r > hi)      res.y = hi;
    else if (r < lo) res.y = lo;
    else             res.y = r;
    return res;
  endfunction

endpackage

// File: rtl/mxm_mac_lane.sv
// One MAC lane: signed multiply, accumulate, and the rounded/saturated view of the running sum.
// y/sat reflect the sum including the current beat so the top can register them on the last beat.
module mxm_mac_lane
  import mxm_pkg::*;
#(
  parameter int W     = 8,
  parameter int F     = 4,
  parameter int ACC_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         first,
  input  logic         last,
  input  logic [W-1:0] a,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         sat
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] sum_next;
  rs_t                     rs;
  logic                    rs_unused;

  assign prod     = (2*W)'($signed(a)) * (2*W)'($signed(x));
  // The first beat overwrites the accumulator, so no separate clear cycle exists.
  assign sum_next = first ? ACC_W'(prod) : acc_reg + ACC_W'(prod);
  assign rs       = round_sat(RS_W'(sum_next), W, F);
  assign y        = rs.y[W-1:0];
  assign sat      = rs.sat;
  assign rs_unused = ^rs.y[RS_W-1:W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= last ? '0 : sum_next;
    end
  end

endmodule

// File: rtl/mxm_mac_array.sv
// Multi-lane streaming dot-product engine: X broadcast to LANES rows, result per lane after n_len beats.
// Owns the beat counter, length latch, valid/ready handshakes and the output register.
module mxm_mac_array
  import mxm_pkg::*;
#(
  parameter int W     = 8,
  parameter int F     = 4,
  parameter int LANES = 4,
  parameter int NMAX  = 256,
  parameter int NW    = nw_of(NMAX),
  parameter int ACC_W = acc_w_of(W, NMAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NW-1:0]        n_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   a_in,
  input  logic [W-1:0]         x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y_out,
  output logic [LANES-1:0]     sat_flags,
  output logic                 sat_sticky
);

  logic [NW-1:0]      cnt_reg;
  logic [NW-1:0]      len_reg;
  logic [NW-1:0]      n_clamp;
  logic [NW-1:0]      len_eff;
  logic               first;
  logic               last;
  logic               fire;
  logic [LANES*W-1:0] y_next;
  logic [LANES-1:0]   sat_next;

  always_comb begin
    if (n_len == '0)             n_clamp = NW'(1);
    else if (n_len > NW'(NMAX))  n_clamp = NW'(NMAX);
    else                         n_clamp = n_len;
  end

  // The length in force is the live n_len only on the first beat of a vector.
  assign first    = (cnt_reg == '0);
  assign len_eff  = first ? n_clamp : len_reg;
  assign last     = (cnt_reg == len_eff - NW'(1));
  assign in_ready = rst && !(last && out_valid && !out_ready);
  assign fire     = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mxm_mac_lane #(
        .W     (W),
        .F     (F),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .en    (fire),
        .first (first),
        .last  (last),
        .a     (a_in[lane_lsb(gi, W) +: W]),
        .x     (x_in),
        .y     (y_next[lane_lsb(gi, W) +: W]),
        .sat   (sat_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg    <= '0;
      len_reg    <= NW'(1);
      out_valid  <= 1'b0;
      y_out      <= '0;
      sat_flags  <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (fire) begin
        if (first) len_reg <= n_clamp;
        cnt_reg <= last ? '0 : cnt_reg + NW'(1);
      end
      // A new result may replace one being handshaked in the same cycle.
      if (fire && last) begin
        out_valid  <= 1'b1;
        y_out      <= y_next;
        sat_flags  <= sat_next;
        sat_sticky <= sat_sticky | (|sat_next);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mxm_mac_array.sv
// Directed bench for mxm_mac_array: a reference model pushes expected results as beats are
// accepted and a monitor pops and compares them on every output handshake.
module tb_mxm_mac_array;

  localparam int W     = 8;
  localparam int F     = 4;
  localparam int LANES = 4;
  localparam int NMAX  = 256;
  localparam int NW    = $clog2(NMAX + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NW-1:0]      n_len = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*W-1:0] a_in = '0;
  logic [W-1:0]       x_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [LANES*W-1:0] y_out;
  logic [LANES-1:0]   sat_flags;
  logic               sat_sticky;

  always #5 clk = ~clk;

  mxm_mac_array #(
    .W     (W),
    .F     (F),
    .LANES (LANES),
    .NMAX  (NMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .n_len      (n_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_out      (y_out),
    .sat_flags  (sat_flags),
    .sat_sticky (sat_sticky)
  );

  typedef logic [LANES*W+LANES-1:0] exp_t;

  int     checks = 0;
  int     passed = 0;
  exp_t   sb[$];
  longint m_acc[LANES];
  int     m_cnt = 0;
  int     m_len = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int clampn(input int n);
    if (n <= 0) return 1;
    if (n > NMAX) return NMAX;
    return n;
  endfunction

  function automatic logic [W:0] exp_lane(input longint s);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (F > 0) r = (s + (longint'(1) << (F - 1))) >>> F;
    else       r = s;
    if (r > hi) return {1'b1, W'(hi)};
    if (r < lo) return {1'b1, W'(lo)};
    return {1'b0, W'(r)};
  endfunction

  task automatic model_beat(input logic [LANES*W-1:0] a, input logic [W-1:0] x, input int n);
    exp_t       e;
    logic       s;
    logic [W-1:0] yv;
    longint     p;
    if (m_cnt == 0) m_len = clampn(n);
    for (int l = 0; l < LANES; l++) begin
      p = longint'($signed(a[l*W +: W])) * longint'($signed(x));
      m_acc[l] = (m_cnt == 0) ? p : m_acc[l] + p;
    end
    m_cnt++;
    if (m_cnt == m_len) begin
      m_cnt = 0;
      e = '0;
      for (int l = 0; l < LANES; l++) begin
        {s, yv} = exp_lane(m_acc[l]);
        e[l*W +: W] = yv;
        e[LANES*W + l] = s;
      end
      sb.push_back(e);
    end
  endtask

  // Presents one beat and holds it until accepted; returns just after the accepting edge.
  task automatic beat(input logic [LANES*W-1:0] a, input logic [W-1:0] x, input int n);
    int waited = 0;
    a_in = a;
    x_in = x;
    n_len = NW'(n);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      if (!in_ready) waited++;
    end while (!in_ready && waited < 100);
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else model_beat(a, x, n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("y_out", 64'(y_out), 64'(e[LANES*W-1:0]));
        chk("sat_flags", 64'(sat_flags), 64'(e[LANES*W +: LANES]));
      end
      $display("result y_out=%h sat_flags=%b sat_sticky=%b", y_out, sat_flags, sat_sticky);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y_out", 64'(y_out), 64'd0);
    chk("rst_sat_flags", 64'(sat_flags), 64'd0);
    chk("rst_sat_sticky", 64'(sat_sticky), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic: 16*16 + 16*32 + 16*48 = 1536 -> 0x60 on every lane
    beat({4{8'h10}}, 8'h10, 3);
    beat({4{8'h10}}, 8'h20, 3);
    beat({4{8'h10}}, 8'h30, 3);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_y", 64'(y_out), 64'h60606060);
    chk("basic_flags", 64'(sat_flags), 64'd0);
    chk("basic_sticky", 64'(sat_sticky), 64'd0);

    // Rounding: 8 -> 1, 7 -> 0, -8 -> 0
    beat({4{8'h01}}, 8'h08, 1);
    chk("round_up_y", 64'(y_out), 64'h01010101);
    beat({4{8'h01}}, 8'h07, 1);
    chk("round_down_y", 64'(y_out), 64'h00000000);
    beat({4{8'hFF}}, 8'h08, 1);
    chk("round_neg_y", 64'(y_out), 64'h00000000);

    // Saturation on lanes 0 (positive) and 1 (negative)
    repeat (4) beat(32'h0000807F, 8'h7F, 4);
    chk("sat_y", 64'(y_out), 64'h0000807F);
    chk("sat_flags_val", 64'(sat_flags), 64'b0011);
    chk("sat_sticky_set", 64'(sat_sticky), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Backpressure: result 1 held, final beat of vector 2 stalls until out_ready rises
    out_ready = 1'b0;
    beat({4{8'h10}}, 8'h10, 2);
    beat({4{8'h10}}, 8'h10, 2);
    chk("bp_valid1", 64'(out_valid), 64'd1);
    chk("bp_y1", 64'(y_out), 64'h20202020);
    beat({4{8'h20}}, 8'h18, 2);
    fork
      beat({4{8'h20}}, 8'h08, 2);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("bp_stall_ready", 64'(in_ready), 64'd0);
          chk("bp_hold_y", 64'(y_out), 64'h20202020);
          chk("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_valid2", 64'(out_valid), 64'd1);
    chk("bp_y2", 64'(y_out), 64'h40404040);
    chk("bp_ready_after", 64'(in_ready), 64'd1);

    // Back-to-back: n_len=1 then n_len=5 with mid-vector change to 2 ignored
    beat($urandom, W'($urandom), 1);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    beat($urandom, W'($urandom), 5);
    chk("b2b_mid_valid_b2", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) beat($urandom, W'($urandom), 2);
    chk("b2b_mid_valid_b5", 64'(out_valid), 64'd0);
    beat($urandom, W'($urandom), 2);
    chk("b2b_last_valid", 64'(out_valid), 64'd1);

    // n_len=0 behaves as 1
    beat($urandom, W'($urandom), 0);
    chk("len0_valid", 64'(out_valid), 64'd1);

    // n_len above NMAX clamps to NMAX
    for (int i = 0; i < NMAX; i++) begin
      beat($urandom, W'($urandom), NMAX + 9);
      if (i == NMAX - 2) chk("lenmax_not_yet", 64'(out_valid), 64'd0);
    end
    chk("lenmax_valid", 64'(out_valid), 64'd1);

    // Reset mid-vector discards partial sums and sticky flag
    beat({4{8'h40}}, 8'h40, 3);
    beat({4{8'h40}}, 8'h40, 3);
    rst = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_sticky", 64'(sat_sticky), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    chk("mrst_y_out", 64'(y_out), 64'd0);
    rst = 1'b1;
    beat({4{8'h10}}, 8'h10, 3);
    beat({4{8'h10}}, 8'h10, 3);
    beat({4{8'h10}}, 8'h10, 3);
    chk("mrst_new_y", 64'(y_out), 64'h30303030);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mxm_mac_array.md
Name: mxm_mac_array

Overview:
- Parametrised multi-lane streaming dot-product engine; successor to the single-lane serial MxM MAC.
- Each accepted beat carries one X element, broadcast to LANES lanes, plus one A element per lane (LANES matrix rows in parallel).
- After n_len beats the engine emits LANES fixed-point results: rounded, shifted and saturated.
- Adds valid/ready handshakes, runtime vector length, per-lane saturation flags, and back-to-back vectors with no bubble.

Parameters:
- W, 8: element and result width, signed two's complement.
- F, 4: fraction bits shared by A, X and Y (Q(W-F).F).
- LANES, 4: parallel MAC lanes.
- NMAX, 256: maximum vector length.
- NW, $clog2(NMAX+1): width of n_len.
- ACC_W, 2*W+$clog2(NMAX): accumulator width; overflow-free by construction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- n_len  in  NW  vector length; sampled on the first beat of each vector.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a_in  in  LANES*W  A elements; lane i occupies bits [i*W +: W].
- x_in  in  W  X element, shared by all lanes.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- y_out  out  LANES*W  result per lane, same packing as a_in.
- sat_flags  out  LANES  per-lane saturation occurred for the current y_out.
- sat_sticky  out  1  OR of all saturations since reset.

Behaviour:
- Reset (rst==0 at a clk edge):
  - beat counter = 0; accumulators = 0; out_valid = 0; y_out = 0; sat_flags = 0; sat_sticky = 0.
  - Reset mid-vector discards all partial sums.
  - in_ready is 0 while rst==0.
- Length latch:
  - On an accepted beat with cnt==0, len_q = n_len.
  - n_len==0 is treated as 1; n_len>NMAX is clamped to NMAX.
  - n_len changes mid-vector are ignored.
- Accumulate, per lane:
  - prod = signed(a_i) * signed(x), 2W bits, sign-extended to ACC_W.
  - First beat of a vector: acc = prod, so no clear cycle is needed. Later beats: acc = acc + prod.
  - cnt increments per accepted beat and wraps to 0 after beat len_q-1.
- Finalise, on acceptance of beat len_q-1, in the same cycle, using the final sum s:
  - r = (s + 2^(F-1)) >>> F (round half up, arithmetic shift). If F==0, r = s.
  - y = clamp(r, -2^(W-1), 2^(W-1)-1); sat_flags[i] = 1 if clamped.
  - y_out, sat_flags and out_valid=1 are registered at that edge: latency is 1 cycle after the last beat.
- Output hold:
  - y_out and sat_flags stay stable while out_valid && !out_ready.
  - out_valid clears after a handshake unless a new result loads in the same cycle, in which case it stays 1 and new data appears.
- Backpressure:
  - in_ready = rst && !(cnt==len_eff-1 && out_valid && !out_ready).
  - len_eff is len_q, or the clamped n_len when cnt==0.
  - in_ready is combinational on out_ready. Non-final beats are never stalled.
- in_valid==0 is a bubble: state holds and partial sums persist indefinitely.
- sat_sticky sets on any finalise with any sat_flags bit set; it is cleared only by reset.

Decomposition:
- Package mxm_pkg:
  - NW/ACC_W derivation function.
  - Lane-slice helper.
  - round_sat function (rounding shift plus saturation).
- One sub-module, mxm_mac_lane (W, F, ACC_W), instanced LANES times via generate:
  - Contains one lane's multiply, accumulate, round and saturate.
  - Inputs: first and last strobes, plus an enable.
  - Outputs: y and sat.
- The top level owns the counter, length latch, handshake and output register.

Test Plan:
- Basic: LANES=4, F=4, n_len=3, all a=0x10, x=0x10,0x20,0x30 streamed without gaps -> y_out=0x60 on every lane one cycle after the 3rd beat; sat_flags=0.
- Rounding: n_len=1, a=1, x=8 -> y=1; then a=1, x=7 -> y=0; then a=-1, x=8 -> y=0.
- Saturation: n_len=4, lane0 a=0x7F, x=0x7F -> y=0x7F, sat_flags[0]=1, sat_sticky=1. Lane1 a=0x80, x=0x7F -> y=0x80, sat_flags[1]=1. Other lanes with a=0 -> y=0, flag 0.
- Backpressure: out_ready=0, n_len=2, four consecutive beats. in_ready drops on beat 4, y_out holds result 1. Raise out_ready -> beat 4 accepted that cycle and result 2 appears the next cycle with out_valid still 1.
- Back-to-back with lengths: n_len=1 then n_len=5 (changed to 2 mid-vector) with out_ready=1 -> results at beats 1 and 6. n_len=0 behaves as 1; n_len=NMAX+9 behaves as NMAX.
- Reset mid-vector: drive rst=0 after 2 of 3 beats -> out_valid=0, sat_sticky=0, in_ready=0. After release, a new 3-beat vector yields only its own sum.
